// File: rtl/priority_encoder_serializer.sv
// Priority encoder serializer: streams the index of every set request bit, lowest index first.
// Define PRIORITY_ENCODER_SERIALIZER_B2B_EN to accept the next vector on the last output beat.
module priority_encoder_serializer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned SPLIT          = 4,
  parameter int unsigned IMPLEMENTATION = 0,
  localparam int unsigned WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_vld,
  output logic                 dec_rdy,
  input  logic [WIDTH-1:0]     dec_vec,
  output logic                 enc_vld,
  input  logic                 enc_rdy,
  output logic [WIDTH_LOG-1:0] enc_idx,
  output logic                 enc_lst,
  output logic [WIDTH_LOG:0]   enc_cnt
);

  localparam int unsigned NumGroups = (WIDTH + SPLIT - 1) / SPLIT;
  localparam int unsigned PadW      = NumGroups * SPLIT;
  localparam int unsigned Pow2W     = 1 << WIDTH_LOG;

  // Every encoder variant scans from bit 0 upwards, so bits above the lowest set bit
  // never influence the result.
  function automatic logic [WIDTH_LOG-1:0] enc_linear(input logic [WIDTH-1:0] v);
    logic [WIDTH_LOG-1:0] r;
    logic                 found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && v[i]) begin
        r     = WIDTH_LOG'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [WIDTH_LOG-1:0] enc_onehot(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0]     oh;
    logic [WIDTH_LOG-1:0] r;
    oh = v & (~v + WIDTH'(1));
    r  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (oh[i]) r = r | WIDTH_LOG'(i);
    end
    return r;
  endfunction

  function automatic logic [WIDTH_LOG-1:0] enc_tree(input logic [WIDTH-1:0] v);
    logic [PadW-1:0]      p;
    logic [NumGroups-1:0] any;
    logic [SPLIT-1:0]     grp;
    int unsigned          sel;
    int unsigned          j;
    logic                 found;
    p            = '0;
    p[WIDTH-1:0] = v;
    for (int unsigned g = 0; g < NumGroups; g++) any[g] = |p[g*SPLIT +: SPLIT];
    sel   = 0;
    found = 1'b0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      if (!found && any[g]) begin
        sel   = g;
        found = 1'b1;
      end
    end
    grp   = p[sel*SPLIT +: SPLIT];
    j     = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < SPLIT; k++) begin
      if (!found && grp[k]) begin
        j     = k;
        found = 1'b1;
      end
    end
    return WIDTH_LOG'(sel * SPLIT + j);
  endfunction

  function automatic logic [WIDTH_LOG-1:0] enc_bsearch(input logic [WIDTH-1:0] v);
    logic [Pow2W-1:0] p;
    logic [Pow2W-1:0] m;
    int unsigned      lo;
    p            = '0;
    p[WIDTH-1:0] = v;
    lo           = 0;
    for (int l = int'(WIDTH_LOG) - 1; l >= 0; l--) begin
      m = (Pow2W'(1) << (32'd1 << l)) - Pow2W'(1);
      if (((p >> lo) & m) == '0) lo = lo + (32'd1 << l);
    end
    return WIDTH_LOG'(lo);
  endfunction

  // Ones up to and including the lowest set bit; their count minus one is the index.
  function automatic logic [WIDTH_LOG-1:0] enc_thermo(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    int unsigned      n;
    t = v ^ (v - WIDTH'(1));
    n = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (t[i]) n++;
    end
    return WIDTH_LOG'(n - 1);
  endfunction

  logic [WIDTH-1:0]     rem_q, rem_d, rem_rest;
  logic [WIDTH_LOG:0]   cnt_q, cnt_d;
  logic [WIDTH_LOG-1:0] idx_raw;
  logic                 busy, out_fire, in_fire;

  if (IMPLEMENTATION == 1) begin : g_onehot
    assign idx_raw = enc_onehot(rem_q);
  end else if (IMPLEMENTATION == 2) begin : g_tree
    assign idx_raw = enc_tree(rem_q);
  end else if (IMPLEMENTATION == 3) begin : g_bsearch
    assign idx_raw = enc_bsearch(rem_q);
  end else if (IMPLEMENTATION == 4) begin : g_thermo
    assign idx_raw = enc_thermo(rem_q);
  end else begin : g_linear
    assign idx_raw = enc_linear(rem_q);
  end

  // Clearing the lowest set bit is the same as clearing rem[enc_idx].
  assign rem_rest = rem_q & (rem_q - WIDTH'(1));

  always_comb begin
    busy     = |rem_q;
    enc_vld  = busy;
    enc_idx  = idx_raw;
    enc_lst  = busy && (rem_rest == '0);
    enc_cnt  = busy ? cnt_q : '0;
    out_fire = enc_vld && enc_rdy;
`ifdef PRIORITY_ENCODER_SERIALIZER_B2B_EN
    dec_rdy  = !busy || (out_fire && enc_lst);
`else
    dec_rdy  = !busy;
`endif
    in_fire  = dec_vld && dec_rdy;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    if (out_fire) begin
      rem_d = rem_rest;
      cnt_d = cnt_q + (WIDTH_LOG + 1)'(1);
    end
    if (in_fire) begin
      rem_d = dec_vec;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder_serializer.sv
// Bench for priority_encoder_serializer: all five encoder implementations run in lockstep
// against one scoreboard of expected index beats.
module tb_priority_encoder_serializer;

  localparam int NumImpl = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_vld;
  logic [15:0] dec_vec;
  logic        enc_rdy;
  logic        dec_rdy [NumImpl];
  logic        enc_vld [NumImpl];
  logic [3:0]  enc_idx [NumImpl];
  logic        enc_lst [NumImpl];
  logic [4:0]  enc_cnt [NumImpl];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumImpl; g++) begin : g_dut
    priority_encoder_serializer #(
      .WIDTH          (16),
      .SPLIT          (4),
      .IMPLEMENTATION (g)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dec_vld (dec_vld),
      .dec_rdy (dec_rdy[g]),
      .dec_vec (dec_vec),
      .enc_vld (enc_vld[g]),
      .enc_rdy (enc_rdy),
      .enc_idx (enc_idx[g]),
      .enc_lst (enc_lst[g]),
      .enc_cnt (enc_cnt[g])
    );
  end

  typedef struct packed {
    logic [3:0] idx;
    logic [4:0] cnt;
    logic       lst;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  bit    b2b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_vec(input logic [15:0] v);
    int    total;
    int    n;
    beat_t b;
    total = $countones(v);
    n     = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        b.idx = 4'(i);
        b.cnt = 5'(n);
        b.lst = (n == total - 1);
        exp_q.push_back(b);
        n++;
      end
    end
  endtask

  // One clock cycle: drive inputs, check every instance against the scoreboard head,
  // then advance the model across the coming edge.
  task automatic cycle(input logic vld, input logic [15:0] vec, input logic rdy, output logic acc);
    logic  exp_vld;
    logic  exp_rdy;
    beat_t hd;
    dec_vld = vld;
    dec_vec = vec;
    enc_rdy = rdy;
    #1;
    exp_vld = (exp_q.size() != 0);
    hd      = exp_vld ? exp_q[0] : '0;
    exp_rdy = !exp_vld || (b2b && rdy && hd.lst);
    for (int g = 0; g < NumImpl; g++) begin
      check_eq($sformatf("i%0d dec_rdy", g), 32'(dec_rdy[g]), 32'(exp_rdy));
      check_eq($sformatf("i%0d enc_vld", g), 32'(enc_vld[g]), 32'(exp_vld));
      check_eq($sformatf("i%0d enc_lst", g), 32'(enc_lst[g]), 32'(hd.lst));
      check_eq($sformatf("i%0d enc_cnt", g), 32'(enc_cnt[g]), 32'(hd.cnt));
      if (exp_vld) check_eq($sformatf("i%0d enc_idx", g), 32'(enc_idx[g]), 32'(hd.idx));
    end
    if (enc_vld[0] && rdy) beat_cyc.push_back(cyc);
    acc = vld && exp_rdy;
    if (exp_vld && rdy) exp_q.delete(0);
    if (acc) push_vec(vec);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] vec);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 64) begin
      cycle(1'b1, vec, 1'b1, acc);
      guard++;
    end
  endtask

  task automatic drain(input int stall);
    logic acc;
    int   guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      for (int s = 0; s < stall; s++) cycle(1'b0, 16'h0, 1'b0, acc);
      cycle(1'b0, 16'h0, 1'b1, acc);
      guard++;
    end
  endtask

  // Reset asserted mid-cycle: outputs must go idle without waiting for a clock edge.
  task automatic reset_mid();
    logic acc;
    dec_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int g = 0; g < NumImpl; g++) begin
      check_eq($sformatf("i%0d rst enc_vld", g), 32'(enc_vld[g]), 32'd0);
      check_eq($sformatf("i%0d rst dec_rdy", g), 32'(dec_rdy[g]), 32'd1);
      check_eq($sformatf("i%0d rst enc_lst", g), 32'(enc_lst[g]), 32'd0);
      check_eq($sformatf("i%0d rst enc_cnt", g), 32'(enc_cnt[g]), 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    repeat (3) cycle(1'b0, 16'h0, 1'b1, acc);
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
`ifdef PRIORITY_ENCODER_SERIALIZER_B2B_EN
    b2b = 1'b1;
`else
    b2b = 1'b0;
`endif
    rst_n   = 1'b0;
    dec_vld = 1'b0;
    dec_vec = '0;
    enc_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 16'h0, 1'b1, acc);

    reset_mid();

    send(16'h0100);
    drain(0);
    cycle(1'b0, 16'h0, 1'b1, acc);

    send(16'h8421);
    drain(2);
    cycle(1'b0, 16'h0, 1'b1, acc);

    send(16'h0000);
    cycle(1'b0, 16'h0, 1'b1, acc);
    send(16'hFFFF);
    drain(0);
    cycle(1'b0, 16'h0, 1'b1, acc);

    beat_cyc.delete();
    send(16'h0003);
    send(16'h0004);
    drain(0);
    cycle(1'b0, 16'h0, 1'b1, acc);
    check_eq("b2b beat count", 32'(beat_cyc.size()), 32'd3);
    if (beat_cyc.size() == 3) begin
      check_eq("b2b gap 0-1", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
      check_eq("b2b gap 1-2", 32'(beat_cyc[2] - beat_cyc[1]), b2b ? 32'd1 : 32'd2);
    end

    send(16'h00F0);
    cycle(1'b0, 16'h0, 1'b1, acc);
    cycle(1'b0, 16'h0, 1'b1, acc);
    reset_mid();
    send(16'h0002);
    drain(0);
    cycle(1'b0, 16'h0, 1'b1, acc);

    for (int t = 0; t < 20; t++) begin
      send(16'($urandom));
      drain(int'($urandom_range(0, 1)));
    end
    cycle(1'b0, 16'h0, 1'b1, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
